mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width.
REQ-002 Parameter DW, 32, data width.
REQ-003 Parameter TIMEOUT, 15, max GRANT cycles without mem_ready before abort; legal range 1..255.
REQ-004 Parameter STARVE, 4, consecutive DM grants with IF pending before IF is forced.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 if_req  in  1  fetch request; held with if_addr stable until if_ack.
REQ-008 if_addr  in  AW  fetch address.
REQ-009 if_rdata  out  DW  fetch data, valid only while if_ack=1.
REQ-010 if_ack  out  1  one-cycle fetch completion.
REQ-011 dm_req, dm_we  in  1 each  data request and write enable; held with payload stable until dm_ack.
REQ-012 dm_be  in  4  byte enables; dm_addr  in  AW; dm_wdata  in  DW.
REQ-013 dm_rdata  out  DW  load data, valid only while dm_ack=1; dm_ack  out  1  one-cycle completion.
REQ-014 mem_req, mem_we  out  1 each; mem_be  out  4; mem_addr  out  AW; mem_wdata  out  DW: registered memory-port outputs.
REQ-015 mem_rdata  in  DW; mem_ready  in  1  memory completion, single cycle.
REQ-016 err  out  1  one-cycle pulse on timeout abort.

Function
REQ-017 FSM states: IDLE, GRANT_IF, GRANT_DM; encoding is free.
REQ-018 IDLE arbitration on the sampled cycle:
- DM wins when both request, unless the starve counter equals STARVE, in which case IF wins.
- Sole requester wins.
- No request: stay IDLE.
REQ-019 Starve counter: +1 on each DM grant made while if_req=1; cleared on any IF grant or when if_req=0 in IDLE; saturates at STARVE.
REQ-020 On a grant, the requester's address, we, be and wdata are latched into the mem_* registers and mem_req=1 from the next cycle; IF grants drive mem_we=0 and mem_be=4'hF.
REQ-021 In GRANT_x with mem_ready=1:
- x_ack=1 combinationally that cycle.
- x_rdata = mem_rdata (0 for DM writes).
- mem_req drops and the FSM returns to IDLE on the next edge.
REQ-022 Minimum transaction: request sampled in cycle N, mem_req high in N+1, ack earliest N+1 (if mem_ready=1 in N+1); the next grant is sampled no earlier than N+2.
REQ-023 Outside a completing GRANT cycle, if_ack and dm_ack are 0 and if_rdata and dm_rdata are 0.
REQ-024 if_ack and dm_ack are never 1 in the same cycle.
REQ-025 Wait counter clears on grant and increments each GRANT cycle with mem_ready=0.
REQ-026 Timeout: when the wait counter reaches TIMEOUT:
- Ack the owner with rdata=0.
- Pulse err.
- Drop mem_req and return to IDLE.
REQ-027 mem_ready in IDLE is ignored.
REQ-028 A requester deasserting req before ack is illegal; the transaction completes regardless.

Reset
REQ-029 On rst=1 at an edge:
- FSM=IDLE.
- mem_req, mem_we, err, if_ack, dm_ack = 0.
- mem_addr, mem_wdata, mem_be = 0.
- Starve and wait counters = 0.
REQ-030 Reset mid-transaction abandons it with no ack, and mem_req is 0 in the following cycle.

Structure
REQ-031 State encoding localparams and default AW/DW/TIMEOUT/STARVE values live in the shared header mem_arb_pkg.
REQ-032 One sub-module, mem_arb_timer (wait counter plus timeout compare); arbitration and the FSM stay in mem_arbiter.

Verification
REQ-033 Scenario 1: rst high 2 cycles, then low with no requests -> all outputs 0, state IDLE.
REQ-034 Scenario 2: if_req with if_addr=0x100, mem_ready=1 one cycle after mem_req, mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0; if_ack=1 with if_rdata=0x00500093 exactly one cycle.
REQ-035 Scenario 3: if_req and dm_req (dm_we=1, be=4'h3, addr=0x2000, wdata=0xBEEF) both asserted in the same cycle -> DM served first with mem_we=1 and mem_be=4'h3, then IF; dm_ack precedes if_ack.
REQ-036 Scenario 4: if_req held while 5 back-to-back DM requests arrive, STARVE=4 -> the 5th grant goes to IF, and DM resumes after.
REQ-037 Scenario 5: DM load, mem_ready held 0, TIMEOUT=15 -> dm_ack=1 with dm_rdata=0 and err=1 in the 15th wait cycle; IDLE next.
REQ-038 Scenario 6: rst asserted 2 cycles into a waiting IF grant -> no if_ack, mem_req=0 the next cycle, and a new request afterwards is served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the default widths and limits, the FSM state encoding, and the
// saturating-increment helper used by the arbitration counters.
package mem_arb_pkg;

  localparam int AW_DEF      = 32;
  localparam int DW_DEF      = 32;
  localparam int TIMEOUT_DEF = 15;
  localparam int STARVE_DEF  = 4;

  // Both the starve and wait counters fit 8 bits (limits are at most 255).
  localparam int CNT_W = 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GRANT_IF = 2'd1;
  localparam logic [1:0] ST_GRANT_DM = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    GRANT_IF = ST_GRANT_IF,
    GRANT_DM = ST_GRANT_DM
  } arb_state_e;

  // Increment that holds once the limit is reached.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic [CNT_W-1:0] lim);
    logic [CNT_W-1:0] res;
    if (val < lim) begin
      res = val + 8'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Wait counter for an outstanding memory grant.
// Ports: clk/rst (sync, active-high); clr restarts the count on a new grant;
// run is high while a grant is outstanding; ready is the memory completion;
// timeout flags the grant cycle in which the wait count reaches TIMEOUT.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  input  logic ready,
  output logic timeout
);

  // The abort cycle is the one whose increment would make the count TIMEOUT.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_r;

  // Wait-cycle counter: restarts on grant, counts unready grant cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_r <= 8'd0;
    end else if (clr) begin
      wait_r <= 8'd0;
    end else if (run && !ready) begin
      wait_r <= wait_r + 8'd1;
    end else begin
      wait_r <= wait_r;
    end
  end

  assign timeout = run && !ready && (wait_r == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-ported memory.
// Ports: clk, rst (sync, active-high); fetch master if_req/if_addr ->
// if_rdata/if_ack; data master dm_req/dm_we/dm_be/dm_addr/dm_wdata ->
// dm_rdata/dm_ack; registered memory port mem_req/mem_we/mem_be/mem_addr/
// mem_wdata with mem_rdata/mem_ready back; err pulses on a timeout abort.
// Data master has priority, except that the fetch master is forced through
// after STARVE consecutive data grants taken while it was waiting.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int STARVE  = STARVE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE);

  arb_state_e       state_r, state_s;
  logic [CNT_W-1:0] starve_r;
  logic             grant_if_s, grant_dm_s, in_grant_s, done_s, timeout_s;
  logic             mem_req_r, mem_we_r;
  logic [3:0]       mem_be_r;
  logic [AW-1:0]    mem_addr_r;
  logic [DW-1:0]    mem_wdata_r;

  assign in_grant_s = (state_r != IDLE);
  // A reset cycle never completes the outstanding transaction.
  assign done_s     = in_grant_s && (mem_ready || timeout_s) && !rst;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant_if_s | grant_dm_s),
    .run     (in_grant_s),
    .ready   (mem_ready),
    .timeout (timeout_s)
  );

  // Idle-cycle arbitration: data first unless fetch has been starved.
  always_comb begin
    grant_if_s = 1'b0;
    grant_dm_s = 1'b0;
    if (state_r == IDLE) begin
      if (dm_req && !(if_req && (starve_r == STARVE_LIM))) begin
        grant_dm_s = 1'b1;
      end else if (if_req) begin
        grant_if_s = 1'b1;
      end else begin
        grant_if_s = 1'b0;
      end
    end else begin
      grant_dm_s = 1'b0;
    end
  end

  // Next-state and completion outputs.
  always_comb begin
    state_s  = state_r;
    if_ack   = 1'b0;
    dm_ack   = 1'b0;
    if_rdata = {DW{1'b0}};
    dm_rdata = {DW{1'b0}};
    err      = in_grant_s && timeout_s && !rst;
    case (state_r)
      IDLE: begin
        if (grant_dm_s) begin
          state_s = GRANT_DM;
        end else if (grant_if_s) begin
          state_s = GRANT_IF;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT_IF: begin
        if (done_s) begin
          state_s = IDLE;
          if_ack  = 1'b1;
          // Timeout aborts return zero data.
          if_rdata = mem_ready ? mem_rdata : {DW{1'b0}};
        end else begin
          state_s = GRANT_IF;
        end
      end
      GRANT_DM: begin
        if (done_s) begin
          state_s = IDLE;
          dm_ack  = 1'b1;
          // Stores and timeout aborts return zero data.
          dm_rdata = (mem_ready && !mem_we_r) ? mem_rdata : {DW{1'b0}};
        end else begin
          state_s = GRANT_DM;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Starve counter: counts data grants taken over a waiting fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_r <= 8'd0;
    end else if (state_r == IDLE) begin
      if (grant_if_s || !if_req) begin
        starve_r <= 8'd0;
      end else if (grant_dm_s) begin
        starve_r <= sat_inc(starve_r, STARVE_LIM);
      end else begin
        starve_r <= starve_r;
      end
    end else begin
      starve_r <= starve_r;
    end
  end

  // Memory-port registers: payload captured at grant, request held until done.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= 4'h0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
    end else if (grant_dm_s) begin
      mem_req_r   <= 1'b1;
      mem_we_r    <= dm_we;
      mem_be_r    <= dm_be;
      mem_addr_r  <= dm_addr;
      mem_wdata_r <= dm_wdata;
    end else if (grant_if_s) begin
      mem_req_r   <= 1'b1;
      mem_we_r    <= 1'b0;
      mem_be_r    <= 4'hF;
      mem_addr_r  <= if_addr;
      mem_wdata_r <= {DW{1'b0}};
    end else if (done_s) begin
      mem_req_r   <= 1'b0;
    end else begin
      mem_req_r   <= mem_req_r;
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_be    = mem_be_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: requester agents, a memory responder
// with programmable latency, and an in-order scoreboard of expected grants.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be, mem_be;
  logic        mem_req, mem_we, mem_ready, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  exp_t        exp_q[$];
  cmd_t        dm_cmd_q[$];
  logic [31:0] if_cmd_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          resp_lat = 0;
  bit          resp_en  = 1'b1;
  bit          if_abort = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic push_if(input logic [31:0] a);
    exp_t e;
    e.is_dm = 1'b0; e.we = 1'b0; e.be = 4'hF; e.addr = a; e.wdata = 32'h0;
    e.rdata = mem_model(a); e.err = 1'b0; e.cyc = resp_lat + 1;
    exp_q.push_back(e);
  endtask

  task automatic push_dm(input bit we, input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] wd, input bit to);
    exp_t e;
    cmd_t c;
    e.is_dm = 1'b1; e.we = we; e.be = be; e.addr = a; e.wdata = wd;
    e.rdata = (we || to) ? 32'h0 : mem_model(a);
    e.err = to; e.cyc = to ? 15 : resp_lat + 1;
    exp_q.push_back(e);
    c.we = we; c.be = be; c.addr = a; c.wdata = wd;
    dm_cmd_q.push_back(c);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && if_cmd_q.size() == 0 && dm_cmd_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_eq("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Fetch requester: holds if_req until ack (or an abort by reset).
  initial begin : if_agent
    bit got, aborted;
    if_req = 1'b0; if_addr = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (if_cmd_q.size() > 0) begin
        if_addr = if_cmd_q.pop_front();
        if_req = 1'b1; got = 1'b0; aborted = 1'b0;
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          if (if_ack) begin got = 1'b1; break; end
          if (if_abort) begin aborted = 1'b1; break; end
        end
        if (!got && !aborted) check_eq("if_ack_timeout", 32'd0, 32'd1);
      end else begin
        if_req = 1'b0;
      end
    end
  end

  // Data requester: holds dm_req and payload until ack.
  initial begin : dm_agent
    bit got;
    cmd_t c;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (dm_cmd_q.size() > 0) begin
        c = dm_cmd_q.pop_front();
        dm_req = 1'b1; dm_we = c.we; dm_be = c.be; dm_addr = c.addr; dm_wdata = c.wdata;
        got = 1'b0;
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          if (dm_ack) begin got = 1'b1; break; end
        end
        if (!got) check_eq("dm_ack_timeout", 32'd0, 32'd1);
      end else begin
        dm_req = 1'b0;
      end
    end
  end

  // Memory responder: ready after resp_lat waiting cycles; noisy while idle.
  initial begin : responder
    int wcnt = 0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (mem_req && !rst) begin
        if (resp_en && wcnt == resp_lat) begin
          mem_ready = 1'b1; mem_rdata = mem_model(mem_addr);
        end else begin
          mem_ready = 1'b0; mem_rdata = $urandom();
        end
        wcnt++;
      end else begin
        mem_ready = 1'b1; mem_rdata = $urandom();
        wcnt = 0;
      end
    end
  end

  // Monitor: checks grant payloads and completions against the scoreboard.
  initial begin : monitor
    int   gcyc = 0;
    logic req_q = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        gcyc = 0; req_q = 1'b0;
      end else begin
        if (mem_req) gcyc++; else gcyc = 0;
        if (mem_req && !req_q) begin
          if (exp_q.size() == 0) begin
            check_eq("spurious_grant", 32'd1, 32'd0);
          end else begin
            e = exp_q[0];
            check_eq("grant_addr", mem_addr, e.addr);
            check_eq("grant_we", 32'(mem_we), 32'(e.we));
            check_eq("grant_be", 32'(mem_be), 32'(e.be));
            if (e.is_dm) check_eq("grant_wdata", mem_wdata, e.wdata);
          end
        end
        check_eq("ack_exclusive", 32'(if_ack & dm_ack), 32'd0);
        if (if_ack || dm_ack) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_ack", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check_eq("ack_port_dm", 32'(dm_ack), 32'(e.is_dm));
            check_eq("ack_rdata", dm_ack ? dm_rdata : if_rdata, e.rdata);
            check_eq("ack_err", 32'(err), 32'(e.err));
            check_eq("ack_latency", 32'(gcyc), 32'(e.cyc));
          end
        end else begin
          check_eq("idle_rdata", if_rdata | dm_rdata, 32'h0);
          check_eq("idle_err", 32'(err), 32'd0);
        end
        req_q = mem_req;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit seen;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state with no requests.
    @(negedge clk);
    check_eq("rst_if_ack", 32'(if_ack), 32'd0);
    check_eq("rst_dm_ack", 32'(dm_ack), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_be", 32'(mem_be), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_rdata", if_rdata | dm_rdata, 32'h0);
    repeat (2) @(negedge clk);

    // Single fetch, memory ready one cycle after mem_req.
    resp_lat = 1;
    push_if(32'h0000_0100);
    if_cmd_q.push_back(32'h0000_0100);
    wait_drain();

    // Simultaneous requests: data store first, then fetch.
    resp_lat = 0;
    push_dm(1'b1, 4'h3, 32'h0000_2000, 32'h0000_BEEF, 1'b0);
    push_if(32'h0000_0104);
    if_cmd_q.push_back(32'h0000_0104);
    wait_drain();

    // Starvation: four data grants, forced fetch, then data resumes.
    resp_lat = 2;
    for (int i = 0; i < 4; i++) begin
      push_dm(1'b0, 4'hF, 32'h0000_3000 + 32'(4 * i), 32'h0, 1'b0);
    end
    push_if(32'h0000_0200);
    push_dm(1'b1, 4'hC, 32'h0000_3100, 32'h1234_5678, 1'b0);
    if_cmd_q.push_back(32'h0000_0200);
    wait_drain();

    // Timeout on a data load with the memory never ready.
    resp_en = 1'b0;
    push_dm(1'b0, 4'hF, 32'h0000_4000, 32'h0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dm_ack) begin seen = 1'b1; break; end
    end
    check_eq("timeout_ack_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check_eq("timeout_idle_mem_req", 32'(mem_req), 32'd0);
    resp_en = 1'b1;
    wait_drain();

    // Reset in the middle of a waiting fetch grant.
    resp_lat = 10;
    push_if(32'h0000_0180);
    if_cmd_q.push_back(32'h0000_0180);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1'b1; break; end
    end
    check_eq("abort_grant_seen", 32'(seen), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; if_abort = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("abort_no_ack_rst", 32'(if_ack), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_mem_req", 32'(mem_req), 32'd0);
    check_eq("abort_no_ack", 32'(if_ack), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; if_abort = 1'b0;
    repeat (2) @(negedge clk);
    resp_lat = 1;
    push_if(32'h0000_01C0);
    if_cmd_q.push_back(32'h0000_01C0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
